mdu_iter: RTL and testbench
===========================

// Module: mdu_iter
// PURPOSE
//  Iterative RV32M multiply/divide unit, one result bit per cycle.
//  Takes RS1/RS2 operands read from the register file and the destination index.
//  Writes its result back through the register file's single write port (W_EN/W_ADDR/W_DATA).
//  Multi-cycle: the core stalls on BUSY.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count = XLEN
// PORTS
//  CLK     in   1     clock, all state on posedge
//  RST     in   1     asynchronous, active-high reset
//  START   in   1     request; sampled only when BUSY=0
//  OP      in   3     funct3: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  RS1     in   XLEN  operand A (dividend / multiplicand)
//  RS2     in   XLEN  operand B (divisor / multiplier)
//  RD      in   5     destination register index
//  FLUSH   in   1     abort in-flight op, no writeback
//  BUSY    out  1     high from the cycle after START is accepted until return to IDLE
//  DONE    out  1     1-cycle completion pulse
//  W_EN    out  1     register-file write enable (1-cycle pulse)
//  W_ADDR  out  5     register-file write index
//  W_DATA  out  XLEN  result
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; BUSY, DONE and W_EN = 0; W_ADDR = 0; W_DATA = 0; counter = 0.
//  - FSM states: IDLE -> CALC -> FIN -> IDLE.
//      IDLE -> CALC: on START & !FLUSH. OP, RS1, RS2 and RD are latched on this edge (edge N).
//      Later input changes are ignored.
//      CALC: runs XLEN iterations. Counter counts 0..XLEN-1. At XLEN-1 the FSM goes to FIN.
//      FIN: DONE=1 for one cycle; W_EN=1 for one cycle unless RD==0; returns to IDLE.
//  - Latency: DONE/W_EN high in the cycle following edge N+XLEN+1 (33 edges at XLEN=32).
//  - Back-to-back: START may be accepted in the cycle after FIN (IDLE again).
//  - START while BUSY: ignored entirely; no queueing.
//  - Outputs are registered. W_DATA/W_ADDR hold their last value outside FIN.
//  - MUL: shift-add on |A|,|B|, giving a 2*XLEN-bit product.
//      Signedness: MUL/MULH signed x signed; MULHSU signed A x unsigned B; MULHU unsigned.
//      The product is negated when the operand signs differ.
//      MUL returns the low XLEN bits; the MULH* ops return the high XLEN bits.
//  - DIV: restoring division on |A|,|B|.
//      Quotient is negated if the signs differ (DIV only). Remainder takes the sign of A (REM only).
//  - Divide by zero (B==0):
//      DIV/DIVU -> all ones; REM/REMU -> A.
//      Full latency unless MDU_EARLY_OUT_EN is defined.
//  - Signed overflow (A==-2^(XLEN-1), B==-1): DIV -> A; REM -> 0.
//  - FLUSH:
//      In CALC or FIN: next state IDLE, BUSY=0 next cycle, no W_EN or DONE.
//      In IDLE: wins over a simultaneous START, so the START is dropped.
//  - Async RST mid-op: abort with no writeback; all outputs return to reset values.
// CONFIGURATION
//  MDU_EARLY_OUT_EN defined:
//    Divide-by-zero or either MUL operand == 0 is detected at START.
//    The FSM skips CALC and goes IDLE -> FIN, so DONE/W_EN are high in the cycle after edge N+1.
//    Results are identical to the full path.
//  MDU_EARLY_OUT_EN undefined:
//    Every op takes the full XLEN+1 edge latency.
//    No zero-detect logic is built.
// TESTING
//  1 MUL RS1=7 RS2=0xFFFFFFFD RD=5 -> W_EN once at edge N+33, W_ADDR=5, W_DATA=0xFFFFFFEB.
//  2 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//    MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
//  3 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
//    DIV 0xFFFFFFF9 (-7)/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
//  4 DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100 (edge N+33; edge N+1 with MDU_EARLY_OUT_EN).
//  5 START held high during CALC with new operands -> ignored; exactly one W_EN, carrying the first result.
//    RD=0 -> DONE pulses, W_EN stays 0.
//  6 FLUSH at CALC cycle 10 -> BUSY=0 next cycle, no DONE/W_EN.
//    RST asserted mid-CALC -> outputs 0 immediately; a new START after release completes normally.

Source files
------------

// File: rtl/mdu_iter_if.sv
// Register-file side bundle of the iterative multiply/divide unit.
// The core drives requests (master); the MDU answers and writes back (slave).
interface mdu_iter_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            start;
  logic            flush;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [4:0]      rd;

  logic            busy;
  logic            done;
  logic            w_en;
  logic [4:0]      w_addr;
  logic [XLEN-1:0] w_data;

  modport master (
    output start, flush, op, rs1, rs2, rd,
    input  busy, done, w_en, w_addr, w_data
  );

  modport slave (
    input  start, flush, op, rs1, rs2, rd,
    output busy, done, w_en, w_addr, w_data
  );

endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit producing one result bit per cycle.
// Multiply is shift-add on operand magnitudes, divide is restoring division;
// signs are re-applied once the XLEN iterations complete.
// Optional feature: define MDU_EARLY_OUT_EN to skip the iterations for a
// zero multiplier operand or a zero divisor.
module mdu_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  mdu_iter_if.slave  bus
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;      // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;      // multiplier shifting out / dividend->quotient
  logic [XLEN-1:0] a_q, a_d;        // |A|, the multiplicand addend
  logic [XLEN-1:0] b_q, b_d;        // |B|, the divisor
  logic [XLEN-1:0] a_raw_q, a_raw_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic            b_zero_q, b_zero_d;

  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            w_en_q, w_en_d;
  logic [4:0]      w_addr_q, w_addr_d;
  logic [XLEN-1:0] w_data_q, w_data_d;

  logic            a_sgn_c, b_sgn_c;
  logic            a_neg_c, b_neg_c;
  logic [XLEN-1:0] a_abs_c, b_abs_c;
  logic [XLEN:0]   mul_sum_c;
  logic [XLEN:0]   rem_shift_c;
  logic [XLEN-1:0] rem_diff_c;
  logic            rem_ge_c;
  logic [2*XLEN-1:0] prod_c, prod_s_c;
  logic [XLEN-1:0] quo_s_c, rem_s_c;
  logic [XLEN-1:0] result_c;
`ifdef MDU_EARLY_OUT_EN
  logic            early_c;
`endif

  // Operand signedness and magnitudes for the request on the bus
  always_comb begin
    if (bus.op[2]) begin
      a_sgn_c = ~bus.op[0];
      b_sgn_c = ~bus.op[0];
    end else begin
      a_sgn_c = (bus.op[1:0] != 2'b11);
      b_sgn_c = ~bus.op[1];
    end
    a_neg_c = a_sgn_c & bus.rs1[XLEN-1];
    b_neg_c = b_sgn_c & bus.rs2[XLEN-1];
    a_abs_c = a_neg_c ? (~bus.rs1 + XLEN'(1)) : bus.rs1;
    b_abs_c = b_neg_c ? (~bus.rs2 + XLEN'(1)) : bus.rs2;
  end

`ifdef MDU_EARLY_OUT_EN
  // Zero operands whose result needs no iteration
  always_comb begin
    if (bus.op[2]) early_c = (bus.rs2 == '0);
    else           early_c = (bus.rs1 == '0) || (bus.rs2 == '0);
  end
`endif

  // One iteration step of each datapath
  always_comb begin
    mul_sum_c   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    rem_shift_c = {hi_q, lo_q[XLEN-1]};
    rem_ge_c    = (rem_shift_c >= {1'b0, b_q});
    rem_diff_c  = rem_shift_c[XLEN-1:0] - b_q;
  end

  // Final sign correction and special-case selection
  always_comb begin
    prod_c   = {hi_q, lo_q};
    prod_s_c = neg_res_q ? (~prod_c + (2*XLEN)'(1)) : prod_c;
    quo_s_c  = neg_res_q ? (~lo_q + XLEN'(1)) : lo_q;
    rem_s_c  = neg_rem_q ? (~hi_q + XLEN'(1)) : hi_q;
    if (!op_q[2]) begin
      result_c = (op_q[1:0] == 2'b00) ? prod_s_c[XLEN-1:0] : prod_s_c[2*XLEN-1:XLEN];
    end else if (b_zero_q) begin
      result_c = op_q[1] ? a_raw_q : '1;
    end else begin
      result_c = op_q[1] ? rem_s_c : quo_s_c;
    end
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_d       = a_q;
    b_d       = b_q;
    a_raw_d   = a_raw_q;
    op_d      = op_q;
    rd_d      = rd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    b_zero_d  = b_zero_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    w_en_d    = 1'b0;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          state_d   = S_CALC;
          busy_d    = 1'b1;
          cnt_d     = '0;
          op_d      = bus.op;
          rd_d      = bus.rd;
          a_raw_d   = bus.rs1;
          a_d       = a_abs_c;
          b_d       = b_abs_c;
          hi_d      = '0;
          lo_d      = bus.op[2] ? a_abs_c : b_abs_c;
          neg_res_d = a_neg_c ^ b_neg_c;
          neg_rem_d = a_neg_c;
          b_zero_d  = (bus.rs2 == '0);
`ifdef MDU_EARLY_OUT_EN
          if (early_c) begin
            state_d = S_FIN;
            lo_d    = '0;
          end
`endif
        end
      end
      S_CALC: begin
        if (bus.flush) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          if (!op_q[2]) begin
            hi_d = mul_sum_c[XLEN:1];
            lo_d = {mul_sum_c[0], lo_q[XLEN-1:1]};
          end else begin
            hi_d = rem_ge_c ? rem_diff_c : rem_shift_c[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], rem_ge_c};
          end
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (!bus.flush) begin
          done_d   = 1'b1;
          w_en_d   = (rd_q != 5'd0);
          w_addr_d = rd_q;
          w_data_d = result_c;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      a_raw_q   <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      w_en_q    <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      a_q       <= a_d;
      b_q       <= b_d;
      a_raw_q   <= a_raw_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      b_zero_q  <= b_zero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      w_en_q    <= w_en_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.w_en   = w_en_q;
  assign bus.w_addr = w_addr_q;
  assign bus.w_data = w_data_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed RV32M corner vectors plus
// randomized operations compared against a plain-arithmetic reference model.
module tb_mdu_iter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mdu_iter_if #(.XLEN(32)) bus ();

  mdu_iter #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural RV32M result computed with wide native arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0]        ua, ub, up;
    logic [31:0]        r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin sp = sa * sb; r = sp[31:0]; end
      3'd1: begin sp = sa * sb; r = sp[63:32]; end
      3'd2: begin sp = sa * $signed(ub); r = sp[63:32]; end
      3'd3: begin up = ua * ub; r = up[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = 32'($signed(a) / $signed(b));
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = 32'($signed(a) % $signed(b));
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    int lat;
    lat = 33;
`ifdef MDU_EARLY_OUT_EN
    if (op[2] ? (b == 32'd0) : (a == 32'd0 || b == 32'd0)) lat = 1;
`endif
    return lat;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Issue one op, then check latency, single write and result
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input string tag);
    int          k;
    int          wen_cnt;
    bit          seen;
    logic [31:0] exp_data;
    int          exp_lat;
    exp_data = ref_result(op, a, b);
    exp_lat  = exp_latency(op, a, b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.rs1   = a;
    bus.rs2   = b;
    bus.rd    = rd;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.rs1   = $urandom();
    bus.rs2   = $urandom();
    bus.rd    = 5'($urandom());
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_accept got %b want 1", tag, bus.busy);
    end
    k = 0; wen_cnt = 0; seen = 1'b0;
    while (!seen && k < 60) begin
      @(posedge clk); #1;
      k++;
      if (bus.w_en === 1'b1) wen_cnt++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || k != exp_lat) begin
      errors++; $display("FAIL %s latency got %0d (seen=%0b) want %0d", tag, k, seen, exp_lat);
    end
    checks++;
    if (wen_cnt != ((rd != 5'd0) ? 1 : 0)) begin
      errors++; $display("FAIL %s w_en_count got %0d want %0d", tag, wen_cnt, (rd != 5'd0) ? 1 : 0);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL %s busy_at_done got %b want 0", tag, bus.busy);
    end
    if (rd != 5'd0) begin
      checks++;
      if (bus.w_addr !== rd) begin
        errors++; $display("FAIL %s w_addr got %0d want %0d", tag, bus.w_addr, rd);
      end
      checks++;
      if (bus.w_data !== exp_data) begin
        errors++; $display("FAIL %s w_data op=%0d a=%h b=%h got %h want %h",
                           tag, op, a, b, bus.w_data, exp_data);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.busy, bus.done, bus.w_en, bus.w_addr, bus.w_data} !== 40'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b w_en=%b w_addr=%0d w_data=%h want all 0",
               bus.busy, bus.done, bus.w_en, bus.w_addr, bus.w_data);
    end
  endtask

  task automatic test_mul();
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, "mul_7_m3");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, "mulh_min_min");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, "mulhu_max");
    run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8, "mulhsu_m1_2");
    run_op(3'd0, 32'd0, 32'h1234_5678, 5'd9, "mul_zero_a");
  endtask

  task automatic test_div();
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, "div_overflow");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, "rem_overflow");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd12, "div_m7_2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd13, "rem_m7_2");
  endtask

  task automatic test_div_zero();
    run_op(3'd5, 32'd100, 32'd0, 5'd14, "divu_by_zero");
    run_op(3'd7, 32'd100, 32'd0, 5'd15, "remu_by_zero");
    run_op(3'd4, 32'hFFFF_FF00, 32'd0, 5'd16, "div_neg_by_zero");
    run_op(3'd6, 32'hFFFF_FF00, 32'd0, 5'd17, "rem_neg_by_zero");
  endtask

  task automatic test_random();
    for (int i = 0; i < 48; i++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
             5'($urandom_range(1, 31)), "random");
    end
  endtask

  task automatic test_start_ignored();
    int  k;
    int  wen_cnt;
    int  late;
    bit  seen;
    bus.start = 1'b1;
    bus.op    = 3'd0;
    bus.rs1   = 32'd3;
    bus.rs2   = 32'd5;
    bus.rd    = 5'd7;
    @(posedge clk); #1;
    bus.op  = 3'd5;
    bus.rs1 = 32'd1000;
    bus.rs2 = 32'd7;
    bus.rd  = 5'd9;
    k = 0; wen_cnt = 0; seen = 1'b0;
    while (!seen && k < 60) begin
      @(posedge clk); #1;
      k++;
      if (bus.w_en === 1'b1) wen_cnt++;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (wen_cnt != 1 || bus.w_addr !== 5'd7 || bus.w_data !== 32'd15) begin
      errors++; $display("FAIL start_while_busy got wen=%0d addr=%0d data=%h want 1/7/0000000f",
                         wen_cnt, bus.w_addr, bus.w_data);
    end
    late = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.w_en === 1'b1 || bus.done === 1'b1 || bus.busy === 1'b1) late++;
    end
    checks++;
    if (late != 0) begin
      errors++; $display("FAIL start_while_busy_extra got %0d active cycles want 0", late);
    end
  endtask

  task automatic test_rd_zero();
    run_op(3'd0, 32'd9, 32'd9, 5'd0, "rd_zero");
    checks++;
    if (bus.done !== 1'b1) begin
      errors++; $display("FAIL rd_zero_done got %b want 1", bus.done);
    end
  endtask

  task automatic test_flush();
    int active;
    bus.start = 1'b1;
    bus.op    = 3'd1;
    bus.rs1   = $urandom();
    bus.rs2   = $urandom();
    bus.rd    = 5'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL flush_calc_busy got %b want 0", bus.busy);
    end
    active = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.w_en === 1'b1) active++;
    end
    checks++;
    if (active != 0) begin
      errors++; $display("FAIL flush_calc_writeback got %0d pulses want 0", active);
    end
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = 3'd0;
    bus.rs1   = 32'd2;
    bus.rs2   = 32'd2;
    bus.rd    = 5'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL flush_idle_busy got %b want 0", bus.busy);
    end
    active = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.w_en === 1'b1) active++;
    end
    checks++;
    if (active != 0) begin
      errors++; $display("FAIL flush_idle_writeback got %0d pulses want 0", active);
    end
  endtask

  task automatic test_reset_mid();
    run_op(3'd0, 32'd3, 32'd5, 5'd4, "pre_reset");
    bus.start = 1'b1;
    bus.op    = 3'd5;
    bus.rs1   = 32'd77;
    bus.rs2   = 32'd3;
    bus.rd    = 5'd20;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.w_en, bus.w_addr, bus.w_data} !== 40'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs got busy=%b done=%b w_en=%b w_addr=%0d w_data=%h want all 0",
               bus.busy, bus.done, bus.w_en, bus.w_addr, bus.w_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(3'd5, 32'd77, 32'd3, 5'd21, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd22, "b2b_first");
    run_op(3'd7, 32'hDEAD_BEEF, 32'd1000, 5'd23, "b2b_second");
    run_op(3'd2, 32'h8000_0001, 32'hFFFF_FFFF, 5'd24, "b2b_third");
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 3'd0;
    bus.rs1   = 32'd0;
    bus.rs2   = 32'd0;
    bus.rd    = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_mul();
    test_div();
    test_div_zero();
    test_start_ignored();
    test_rd_zero();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
